seg_scan_driver: RTL and testbench

Time-multiplexed driver for an N-digit common-anode/cathode seven-segment display in the alarm clock. It accepts packed BCD digits plus per-digit decimal-point, blink and blank controls, and decodes each digit to segments. It scans one digit at a time with a dead-time guard between digits and applies new content only at frame boundaries, so the display never tears. It sits between the time/alarm datapath and the board display pins.

---
 rtl/seg_pkg.sv | 30 +++
 rtl/seg_decoder.sv | 11 +
 rtl/seg_scan_driver.sv | 143 ++++++++++++++
 tb/tb_seg_scan_driver.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Segment constants and the BCD-to-seven-segment code map shared by the display driver.
// Segment vectors are active-high, bit0 = a through bit6 = g.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_ERR   = 7'h79;

  function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
    logic [6:0] s;
    s = SEG_ERR;
    case (bcd)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = SEG_BLANK;
      4'hB:    s = SEG_DASH;
      default: s = SEG_ERR;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational BCD-to-segment decoder, active-high segment output.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  assign seg_o = seg_decode(bcd_i);

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver: per-digit dead cycle, blink, and content updates
// only at frame boundaries so the display never shows a half-updated frame.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned BLINK_FRAMES   = 64,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              seg,
  output logic                    seg_dp,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_start
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PMax = PW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DMax = DW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FMax = FW'(BLINK_FRAMES - 1);
  localparam logic [4*NUM_DIGITS-1:0] DigReset = {NUM_DIGITS{4'hA}};

  logic [PW-1:0] p_q, p_d;
  logic [DW-1:0] d_q, d_d;
  logic [FW-1:0] f_q, f_d;
  logic          b_q, b_d;

  logic [4*NUM_DIGITS-1:0] pend_dig_q, act_dig_q;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_blink_q, act_dp_q, act_blink_q;

  logic [6:0]            seg_q, seg_d;
  logic                  seg_dp_q, seg_dp_d;
  logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
  logic                  frame_start_q;

  logic                  slot_end, boundary, blank;
  logic [3:0]            cur_dig;
  logic                  cur_dp, cur_blink;
  logic [NUM_DIGITS-1:0] sel_hot;
  logic [6:0]            cur_seg, seg_hi;

  assign slot_end = (p_q == PMax);
  assign boundary = slot_end && (d_q == DMax);

  // Mux the active-frame content for the digit currently being scanned.
  always_comb begin
    cur_dig   = 4'hA;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    sel_hot   = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (d_q == DW'(i)) begin
        cur_dig    = act_dig_q[4*i +: 4];
        cur_dp     = act_dp_q[i];
        cur_blink  = act_blink_q[i];
        sel_hot[i] = 1'b1;
      end
    end
  end

  seg_decoder u_seg_decoder (
    .bcd_i (cur_dig),
    .seg_o (cur_seg)
  );

  always_comb begin
    p_d = slot_end ? '0 : p_q + PW'(1);
    d_d = d_q;
    if (slot_end) d_d = (d_q == DMax) ? '0 : d_q + DW'(1);
    f_d = f_q;
    b_d = b_q;
    if (boundary) begin
      if (f_q == FMax) begin
        f_d = '0;
        b_d = ~b_q;
      end else begin
        f_d = f_q + FW'(1);
      end
    end

    blank       = b_q & cur_blink;
    seg_hi      = blank ? SEG_BLANK : cur_seg;
    seg_d       = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
    seg_dp_d    = SEG_ACTIVE_LOW ^ (cur_dp & ~blank);
    // Last cycle of each slot is a dead cycle to stop ghosting into the next digit.
    digit_sel_d = (slot_end ? '0 : sel_hot) ^ {NUM_DIGITS{DIG_ACTIVE_LOW}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q           <= '0;
      d_q           <= '0;
      f_q           <= '0;
      b_q           <= 1'b0;
      pend_dig_q    <= DigReset;
      pend_dp_q     <= '0;
      pend_blink_q  <= '0;
      act_dig_q     <= DigReset;
      act_dp_q      <= '0;
      act_blink_q   <= '0;
      seg_q         <= {7{SEG_ACTIVE_LOW}};
      seg_dp_q      <= SEG_ACTIVE_LOW;
      digit_sel_q   <= {NUM_DIGITS{DIG_ACTIVE_LOW}};
      frame_start_q <= 1'b0;
    end else begin
      p_q <= p_d;
      d_q <= d_d;
      f_q <= f_d;
      b_q <= b_d;
      if (load) begin
        pend_dig_q   <= digits;
        pend_dp_q    <= dp_in;
        pend_blink_q <= blink_mask;
      end
      // A load coinciding with the boundary bypasses pending so it is not a frame late.
      if (boundary) begin
        act_dig_q   <= load ? digits     : pend_dig_q;
        act_dp_q    <= load ? dp_in      : pend_dp_q;
        act_blink_q <= load ? blink_mask : pend_blink_q;
      end
      seg_q         <= seg_d;
      seg_dp_q      <= seg_dp_d;
      digit_sel_q   <= digit_sel_d;
      frame_start_q <= boundary;
    end
  end

  assign seg         = seg_q;
  assign seg_dp      = seg_dp_q;
  assign digit_sel   = digit_sel_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench: a 4-digit active-low-segment instance for scan/tear/blink/reset and a
// 1-digit active-low-select instance for the decode sweep.
module tb_seg_scan_driver;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, load_a;
  logic [15:0] digits_a;
  logic [3:0]  dp_a, blink_a;
  logic [6:0]  seg_a;
  logic        seg_dp_a;
  logic [3:0]  sel_a;
  logic        fs_a;

  logic        rst_b, load_b;
  logic [3:0]  digits_b;
  logic [0:0]  dp_b, blink_b;
  logic [6:0]  seg_b;
  logic        seg_dp_b;
  logic [0:0]  sel_b;
  logic        fs_b;

  int unsigned n_vec;
  int unsigned n_err;

  logic [6:0] seg_map [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h00, 7'h40, 7'h79, 7'h79, 7'h79, 7'h79};

  seg_scan_driver #(
    .NUM_DIGITS     (4),
    .SCAN_DIV       (4),
    .BLINK_FRAMES   (2),
    .SEG_ACTIVE_LOW (1'b1),
    .DIG_ACTIVE_LOW (1'b0)
  ) u_dut_a (
    .clk         (clk),
    .reset       (rst_a),
    .load        (load_a),
    .digits      (digits_a),
    .dp_in       (dp_a),
    .blink_mask  (blink_a),
    .seg         (seg_a),
    .seg_dp      (seg_dp_a),
    .digit_sel   (sel_a),
    .frame_start (fs_a)
  );

  seg_scan_driver #(
    .NUM_DIGITS     (1),
    .SCAN_DIV       (2),
    .BLINK_FRAMES   (1),
    .SEG_ACTIVE_LOW (1'b0),
    .DIG_ACTIVE_LOW (1'b1)
  ) u_dut_b (
    .clk         (clk),
    .reset       (rst_b),
    .load        (load_b),
    .digits      (digits_b),
    .dp_in       (dp_b),
    .blink_mask  (blink_b),
    .seg         (seg_b),
    .seg_dp      (seg_dp_b),
    .digit_sel   (sel_b),
    .frame_start (fs_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic run_a();
    rst_a = 1'b1; load_a = 1'b0; digits_a = 16'h0; dp_a = 4'h0; blink_a = 4'h0;
    ticks(3);
    check_eq("a_rst_seg", seg_a, 7'h7F);
    check_eq("a_rst_dp", seg_dp_a, 1'b1);
    check_eq("a_rst_sel", sel_a, 4'b0000);
    check_eq("a_rst_fs", fs_a, 1'b0);
    rst_a = 1'b0;
    tick();
    check_eq("a_first_seg", seg_a, 7'h7F);
    // Scan order over one frame: three lit cycles then one dead cycle per digit.
    for (int k = 0; k < 16; k++) begin
      if (k != 0) tick();
      check_eq("a_scan_sel", sel_a, (k % 4 == 3) ? 32'h0 : (32'h1 << (k / 4)));
      check_eq("a_scan_fs", fs_a, (k == 15) ? 32'h1 : 32'h0);
    end
    // Mid-frame load at d=1, p=2 must wait for the next boundary.
    ticks(6);
    load_a = 1'b1; digits_a = 16'h1234; dp_a = 4'h0; blink_a = 4'h0;
    tick();
    load_a = 1'b0;
    for (int j = 0; j < 9; j++) begin
      tick();
      check_eq("a_tear_hold", seg_a, 7'h7F);
    end
    check_eq("a_tear_fs", fs_a, 1'b1);
    tick();
    check_eq("a_tear_d0_seg", seg_a, 7'h19);
    check_eq("a_tear_d0_sel", sel_a, 4'b0001);
    ticks(4);
    check_eq("a_tear_d1_seg", seg_a, 7'h30);
    check_eq("a_tear_d1_sel", sel_a, 4'b0010);
    // Load on the boundary cycle of frame 2 lands in frame 3 (a blink-off frame).
    ticks(10);
    load_a = 1'b1; digits_a = 16'h5678; dp_a = 4'b0100; blink_a = 4'b0010;
    tick();
    load_a = 1'b0;
    check_eq("a_bnd_fs", fs_a, 1'b1);
    tick();
    check_eq("a_bnd_d0_seg", seg_a, 7'h00);
    check_eq("a_bnd_d0_dp", seg_dp_a, 1'b1);
    check_eq("a_bnd_d0_sel", sel_a, 4'b0001);
    ticks(4);
    check_eq("a_blink_d1_seg", seg_a, 7'h7F);
    check_eq("a_blink_d1_dp", seg_dp_a, 1'b1);
    check_eq("a_blink_d1_sel", sel_a, 4'b0010);
    ticks(4);
    check_eq("a_blink_d2_seg", seg_a, 7'h02);
    check_eq("a_blink_d2_dp", seg_dp_a, 1'b0);
    check_eq("a_blink_d2_sel", sel_a, 4'b0100);
    ticks(12);
    check_eq("a_unblink_d1_seg", seg_a, 7'h78);
    check_eq("a_unblink_d1_dp", seg_dp_a, 1'b1);
    // Pending load at d=2, then reset (with load still high) discards it.
    ticks(3);
    load_a = 1'b1; digits_a = 16'h9999; dp_a = 4'hF; blink_a = 4'h0;
    tick();
    rst_a = 1'b1;
    tick();
    check_eq("a_mid_rst_seg", seg_a, 7'h7F);
    check_eq("a_mid_rst_dp", seg_dp_a, 1'b1);
    check_eq("a_mid_rst_sel", sel_a, 4'b0000);
    check_eq("a_mid_rst_fs", fs_a, 1'b0);
    rst_a = 1'b0; load_a = 1'b0;
    tick();
    check_eq("a_post_rst_sel", sel_a, 4'b0001);
    check_eq("a_post_rst_seg", seg_a, 7'h7F);
    ticks(16);
    check_eq("a_discard_sel", sel_a, 4'b0001);
    check_eq("a_discard_seg", seg_a, 7'h7F);
    check_eq("a_discard_dp", seg_dp_a, 1'b1);
  endtask

  task automatic run_b();
    rst_b = 1'b1; load_b = 1'b0; digits_b = 4'h0; dp_b = 1'b0; blink_b = 1'b0;
    ticks(3);
    check_eq("b_rst_seg", seg_b, 7'h00);
    check_eq("b_rst_dp", seg_dp_b, 1'b0);
    check_eq("b_rst_sel", sel_b, 1'b1);
    check_eq("b_rst_fs", fs_b, 1'b0);
    rst_b = 1'b0;
    tick();
    check_eq("b_first_sel", sel_b, 1'b0);
    tick();
    check_eq("b_dead_sel", sel_b, 1'b1);
    check_eq("b_fs", fs_b, 1'b1);
    for (int c = 0; c < 16; c++) begin
      digits_b = c[3:0];
      dp_b     = c[0];
      load_b   = 1'b1;
      ticks(2);
      load_b   = 1'b0;
      tick();
      check_eq($sformatf("b_dec_%0h", c), seg_b, seg_map[c]);
      check_eq($sformatf("b_dp_%0h", c), seg_dp_b, c[0]);
      tick();
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    fork
      run_a();
      run_b();
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
